left_shift_seq: RTL and testbench
=================================

LEFT_SHIFT_SEQ -- requirements
Module: left_shift_seq

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits and shift amount at 5 bits.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with the ports listed in REQ-003 to REQ-010.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request pulse; sampled on the rising clk edge.
REQ-006 a  input  32  operand; sampled only on an accepted start.
REQ-007 shamt  input  5  left-shift amount (0-31); sampled only on an accepted start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 result  output  32  registered shifted value; ovf  output  1  registered flag, 1 if any shifted-out bit was 1.

Function
REQ-011 The block SHALL implement three states: IDLE, SHIFT and FINISH, held in an internal register.
REQ-012 In IDLE, start=1 on a clk edge SHALL be accepted: the working register gets a, the counter gets shamt, the sticky overflow gets 0, and the state moves to SHIFT.
REQ-013 In SHIFT, when counter>=2 on a clk edge, the block SHALL shift the working register left by 2 (zero fill), OR its bits [31:30] into the sticky overflow, and reduce the counter by 2.
REQ-014 In SHIFT, when counter==1 on a clk edge, the block SHALL shift left by 1, OR bit [31] into the sticky overflow, and set the counter to 0.
REQ-015 In SHIFT, when counter==0 on a clk edge, the block SHALL move to FINISH and apply no shift.
REQ-016 In FINISH, on the next clk edge, the block SHALL load result from the working register and ovf from the sticky overflow, assert done for exactly that following cycle, and return to IDLE.
REQ-017 The first edge after acceptance SHALL be edge 1; done SHALL be high during the cycle after edge ceil(shamt/2)+2.
REQ-018 busy SHALL be 1 in SHIFT and FINISH, and 0 in IDLE.
REQ-019 start while busy=1 SHALL be ignored; the operands in flight SHALL be unaffected.
REQ-020 start in the cycle where done=1 (state is IDLE) SHALL be accepted, giving back-to-back operation.
REQ-021 result and ovf SHALL hold their values until the next FINISH; a, shamt and start changes SHALL not alter them.
REQ-022 shamt=0 SHALL give result=a and ovf=0.
REQ-023 shamt=31 SHALL take 16 shift cycles: 15 shifts of 2 and one shift of 1.

Reset
REQ-024 While rst_n=0, regardless of clk, the block SHALL force state=IDLE and clear counter, working register, sticky overflow, result, ovf, busy and done to 0.
REQ-025 A reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow for that operation.
REQ-026 The first edge after rst_n rises SHALL be able to accept start.

Verification
REQ-027 Test: a=0xCCCCCCCC, shamt=2 -> result=0x33333330, ovf=1, done in the cycle after edge 3.
REQ-028 Test: a=0x33333333, shamt=1 -> result=0x66666666, ovf=0, done after edge 3.
REQ-029 Test: a=0xCCCCCCCC, shamt=0 -> result=0xCCCCCCCC, ovf=0, done after edge 2.
REQ-030 Test: a=0x00000001, shamt=31 -> result=0x80000000, ovf=0, done after edge 18; a start pulse with a=0xFFFFFFFF at edge 5 is ignored.
REQ-031 Test: a=0x33333333, shamt=4, rst_n low at edge 2 -> busy=0, result=0, no done; a new start at the first edge after release completes normally with result=0x33333330, ovf=1.
REQ-032 Test: back-to-back — start with shamt=3 reissued in the done cycle -> second done follows exactly 4 cycles after the first, and busy stays low only during the done cycle.

Source files
------------

// File: rtl/left_shift_seq.sv
// -----------------------------------------------------------------------------
// left_shift_seq
//
// Multi-cycle logical left shifter. An accepted start captures a 32-bit operand
// and a 5-bit shift amount. The operand is then shifted left by at most two bit
// positions per clock. Any 1 bit that is shifted out of the top sets a sticky
// overflow flag. When the shift amount is used up, the block spends one FINISH
// cycle, registers the result and the overflow flag, and pulses done.
//
// Ports
//   clk     in   1   rising-edge clock for all state
//   rst_n   in   1   asynchronous active-low reset
//   start   in   1   request pulse, accepted only while idle
//   a       in  32   operand, captured on an accepted start
//   shamt   in   5   left-shift amount 0..31, captured on an accepted start
//   busy    out  1   high while an operation is in progress (SHIFT or FINISH)
//   done    out  1   one-cycle completion pulse, coincident with a new result
//   result  out 32   registered shifted value, held until the next completion
//   ovf     out  1   registered flag, 1 if any shifted-out bit was 1
//
// Timing: the accepting edge is edge 0. done is high during the cycle that
// follows edge ceil(shamt/2)+2. A start issued during the done cycle is
// accepted, so operations can run back to back.
// -----------------------------------------------------------------------------
module left_shift_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [4:0]  shamt,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_e;

    state_e      state_q,  state_d;
    logic [4:0]  cnt_q,    cnt_d;     // remaining shift positions
    logic [31:0] work_q,   work_d;    // operand being shifted
    logic        sticky_q, sticky_d;  // OR of every bit shifted out so far
    logic [31:0] result_q, result_d;
    logic        ovf_q,    ovf_d;
    logic        done_q,   done_d;

    // NOTE: every signal written in this block gets a default first. A path
    // that leaves a signal unassigned would infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        sticky_d = sticky_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    work_d   = a;
                    cnt_d    = shamt;
                    sticky_d = 1'b0;
                    state_d  = SHIFT;
                end
            end

            SHIFT: begin
                if (cnt_q >= 5'd2) begin
                    work_d   = {work_q[29:0], 2'b00};
                    sticky_d = sticky_q | (|work_q[31:30]);
                    cnt_d    = cnt_q - 5'd2;
                end else if (cnt_q == 5'd1) begin
                    work_d   = {work_q[30:0], 1'b0};
                    sticky_d = sticky_q | work_q[31];
                    cnt_d    = 5'd0;
                end else begin
                    // No shift is applied on the exit edge. The count has
                    // reached zero, so move to FINISH.
                    state_d = FINISH;
                end
            end

            FINISH: begin
                // The result is published on the edge that leaves FINISH. done
                // is therefore high during the first IDLE cycle, and a new
                // start can be accepted in that same cycle.
                result_d = work_q;
                ovf_d    = sticky_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is updated only with non-blocking assignments, so
    // every register samples the values that were present before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            work_q   <= 32'd0;
            sticky_q <= 1'b0;
            result_q <= 32'd0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            sticky_q <= sticky_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_left_shift_seq.sv
// -----------------------------------------------------------------------------
// tb_left_shift_seq
//
// Directed, table-driven bench for left_shift_seq. Each table record holds an
// operand, a shift amount, the expected result and overflow, and the expected
// number of edges from acceptance to done. Hand-written sequences cover:
//   - a start pulse issued while busy,
//   - result holding after completion,
//   - a reset asserted mid-operation,
//   - back-to-back operations.
// Inputs are driven on the falling edge, and outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_left_shift_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    left_shift_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .shamt  (shamt),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  shamt;
        logic [31:0] exp_res;
        logic        exp_ovf;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one operation from the current falling edge, then wait for done.
    // lat is the edge count (acceptance = edge 0) after which done was seen,
    // or -1 if done never came. When inj_edge > 0, a stray start carrying
    // different operands is presented so that edge inj_edge samples it.
    task automatic run_op(input logic [31:0] av, input logic [4:0] sv, input int inj_edge,
                          output int lat, output bit busy_ok);
        a     = av;
        shamt = sv;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        busy_ok = (busy === 1'b1);
        lat     = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == inj_edge) begin
                start = 1'b1;
                a     = 32'hFFFF_FFFF;
                shamt = 5'd0;
            end
            @(posedge clk);
            @(negedge clk);
            if (k == inj_edge) start = 1'b0;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic check_op(input string name, input vec_t v, input int inj_edge);
        int lat;
        bit busy_ok;
        run_op(v.a, v.shamt, inj_edge, lat, busy_ok);
        check({name, " latency"}, 32'(lat), 32'(v.exp_lat));
        check({name, " result"}, result, v.exp_res);
        check({name, " ovf"}, {31'd0, ovf}, {31'd0, v.exp_ovf});
        check({name, " busy low in done cycle"}, {31'd0, busy}, 32'd0);
        check({name, " busy high while running"}, {31'd0, busy_ok}, 32'd1);
    endtask

    initial begin
        logic [31:0] held_res;
        logic        held_ovf;
        vec_t        v;
        bit          saw_done;

        vecs[0] = '{32'hCCCC_CCCC, 5'd2,  32'h3333_3330, 1'b1, 3};
        vecs[1] = '{32'h3333_3333, 5'd1,  32'h6666_6666, 1'b0, 3};
        vecs[2] = '{32'hCCCC_CCCC, 5'd0,  32'hCCCC_CCCC, 1'b0, 2};
        vecs[3] = '{32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 18};
        vecs[4] = '{32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 1'b1, 3};
        vecs[5] = '{32'h4000_0000, 5'd1,  32'h8000_0000, 1'b0, 3};
        vecs[6] = '{32'h4000_0000, 5'd2,  32'h0000_0000, 1'b1, 3};
        vecs[7] = '{32'h1234_5678, 5'd5,  32'h468A_CF00, 1'b1, 5};
        vecs[8] = '{32'h8000_0000, 5'd31, 32'h0000_0000, 1'b1, 18};
        vecs[9] = '{32'hA000_0001, 5'd3,  32'h0000_0008, 1'b1, 4};

        // Reset state.
        rst_n = 1'b0;
        start = 1'b0;
        a     = 32'd0;
        shamt = 5'd0;
        #3;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset ovf", {31'd0, ovf}, 32'd0);

        // Release reset on a falling edge. The first operation starts there,
        // so the first rising edge after release must accept it.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_op($sformatf("vec%0d", i), vecs[i], 0);
        end

        // done lasts one cycle, and result/ovf hold while the inputs change.
        held_res = result;
        held_ovf = ovf;
        a        = 32'h5555_5555;
        shamt    = 5'd7;
        @(posedge clk);
        @(negedge clk);
        check("done single cycle", {31'd0, done}, 32'd0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("hold result", result, held_res);
        check("hold ovf", {31'd0, ovf}, {31'd0, held_ovf});

        // A start pulse at edge 5 during a long operation is ignored.
        v = '{32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 18};
        check_op("ignore start", v, 5);

        // Reset asserted mid-operation aborts the operation without a done.
        a     = 32'h3333_3333;
        shamt = 5'd4;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort result", result, 32'd0);
        check("abort ovf", {31'd0, ovf}, 32'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("abort no done", {31'd0, saw_done}, 32'd0);
        rst_n = 1'b1;
        v = '{32'h3333_3333, 5'd4, 32'h3333_3330, 1'b1, 4};
        check_op("after reset", v, 0);

        // Back-to-back: the second start is issued in the first done cycle.
        v = '{32'h0000_000F, 5'd3, 32'h0000_0078, 1'b0, 4};
        check_op("b2b first", v, 0);
        v = '{32'hF000_0001, 5'd3, 32'h8000_0008, 1'b1, 4};
        check_op("b2b second", v, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
